// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU/address/branch evaluation feeding the EX/MEM latches,
// plus an iterative shift-add MUL that stalls the front end until it completes.
module execute_stage #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] NOP_IR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_EX_valid,
  input  logic [31:0]       ID_EX_IR,
  input  logic [31:0]       ID_EX_NPC,
  input  logic [DATA_W-1:0] ID_EX_A,
  input  logic [DATA_W-1:0] ID_EX_B,
  input  logic [DATA_W-1:0] ID_EX_Imm,
  output logic              ex_stall,
  output logic              EX_MEM_valid,
  output logic [31:0]       EX_MEM_IR,
  output logic [DATA_W-1:0] EX_MEM_ALU_output,
  output logic [DATA_W-1:0] EX_MEM_B,
  output logic              EX_MEM_cond
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000101;
  localparam logic [5:0] OP_SLT  = 6'b000110;
  localparam logic [5:0] OP_MUL  = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b001001;
  localparam logic [5:0] OP_BEQZ = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b001011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [31:0]       mul_ir;

  logic [5:0]        op;
  logic [DATA_W-1:0] npc_ext;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cond;
  logic [DATA_W-1:0] acc_next;
  logic              mul_start;

  assign op        = ID_EX_IR[31:26];
  assign npc_ext   = DATA_W'(ID_EX_NPC);
  assign mul_start = ID_EX_valid && (op == OP_MUL);

  // Single-cycle result and branch condition for the instruction in ID/EX
  always_comb begin
    alu_result = {DATA_W{1'b0}};
    alu_cond   = 1'b0;
    case (op)
      OP_ADD:  alu_result = ID_EX_A + ID_EX_B;
      OP_SUB:  alu_result = ID_EX_A - ID_EX_B;
      OP_AND:  alu_result = ID_EX_A & ID_EX_B;
      OP_OR:   alu_result = ID_EX_A | ID_EX_B;
      OP_XOR:  alu_result = ID_EX_A ^ ID_EX_B;
      OP_SLT: begin
        if ($signed(ID_EX_A) < $signed(ID_EX_B)) begin
          alu_result = {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
          alu_result = {DATA_W{1'b0}};
        end
      end
      OP_LW, OP_SW: alu_result = ID_EX_A + ID_EX_Imm;
      OP_BEQZ: begin
        alu_result = npc_ext + ID_EX_Imm;
        alu_cond   = (ID_EX_A == {DATA_W{1'b0}});
      end
      OP_J: begin
        alu_result = npc_ext + ID_EX_Imm;
        alu_cond   = 1'b1;
      end
      default: begin
        alu_result = {DATA_W{1'b0}};
        alu_cond   = 1'b0;
      end
    endcase
  end

  // One shift-add iteration; the final cycle's sum is the product loaded into EX/MEM
  always_comb begin
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

  // Front end holds while a MUL is being accepted or is still iterating
  always_comb begin
    case (state)
      IDLE:    ex_stall = mul_start;
      BUSY:    ex_stall = (count != CNT_LAST);
      default: ex_stall = 1'b0;
    endcase
  end

  // FSM, multiplier datapath and EX/MEM latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      count             <= CNT_ZERO;
      mcand             <= {DATA_W{1'b0}};
      mplier            <= {DATA_W{1'b0}};
      acc               <= {DATA_W{1'b0}};
      mul_ir            <= 32'h0;
      EX_MEM_valid      <= 1'b0;
      EX_MEM_IR         <= NOP_IR;
      EX_MEM_ALU_output <= {DATA_W{1'b0}};
      EX_MEM_B          <= {DATA_W{1'b0}};
      EX_MEM_cond       <= 1'b0;
    end else begin
      EX_MEM_B <= ID_EX_B;
      case (state)
        IDLE: begin
          if (mul_start) begin
            mcand             <= ID_EX_A;
            mplier            <= ID_EX_B;
            acc               <= {DATA_W{1'b0}};
            count             <= CNT_ZERO;
            mul_ir            <= ID_EX_IR;
            state             <= BUSY;
            EX_MEM_valid      <= 1'b0;
            EX_MEM_IR         <= NOP_IR;
            EX_MEM_ALU_output <= {DATA_W{1'b0}};
            EX_MEM_cond       <= 1'b0;
          end else if (ID_EX_valid) begin
            EX_MEM_valid      <= 1'b1;
            EX_MEM_IR         <= ID_EX_IR;
            EX_MEM_ALU_output <= alu_result;
            EX_MEM_cond       <= alu_cond;
          end else begin
            EX_MEM_valid      <= 1'b0;
            EX_MEM_IR         <= NOP_IR;
            EX_MEM_ALU_output <= {DATA_W{1'b0}};
            EX_MEM_cond       <= 1'b0;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= {mcand[DATA_W-2:0], 1'b0};
          mplier <= {1'b0, mplier[DATA_W-1:1]};
          if (count == CNT_LAST) begin
            count             <= CNT_ZERO;
            state             <= IDLE;
            EX_MEM_valid      <= 1'b1;
            EX_MEM_IR         <= mul_ir;
            EX_MEM_ALU_output <= acc_next;
            EX_MEM_cond       <= 1'b0;
          end else begin
            count             <= count + CNT_ONE;
            EX_MEM_valid      <= 1'b0;
            EX_MEM_IR         <= NOP_IR;
            EX_MEM_ALU_output <= {DATA_W{1'b0}};
            EX_MEM_cond       <= 1'b0;
          end
        end
        default: begin
          state             <= IDLE;
          count             <= CNT_ZERO;
          EX_MEM_valid      <= 1'b0;
          EX_MEM_IR         <= NOP_IR;
          EX_MEM_ALU_output <= {DATA_W{1'b0}};
          EX_MEM_cond       <= 1'b0;
        end
      endcase
    end
  end

endmodule
